// File: rtl/yrv_aux_uart_rx.sv
// ---------------------------------------------------------------------------
// yrv_aux_uart_rx
// Auxiliary UART receiver for the aux_uart_rx pin of the yrv MCU system.
// Synchronises the serial line, frames start/data/(parity)/stop bits with an
// oversampled baud tick, and buffers received words in a first-word-fall-
// through FIFO. Sticky error flags report framing, overrun and parity errors.
//
// Optional feature macro: AUX_UART_PARITY_EN
//   When defined, adds parity_en_i, parity_odd_i and the sticky parity_err_o.
//   When undefined, frames are start + DATA_W data bits + stop only.
//
// Ports
//   clk_i          cpu clock
//   resetn_i       asynchronous active-low reset
//   rxd_i          async serial input, idle high
//   rx_en_i        receiver enable; low aborts any frame in progress
//   div_val_i      oversample tick period = div_val_i+1 clocks
//   rd_req_i       pop the FIFO head (ignored when empty)
//   err_clr_i      clear the sticky error flags (wins over a same-clock set)
//   rd_data_o      FIFO head word, zero when empty
//   rx_valid_o     FIFO not empty
//   fifo_count_o   number of words held
//   frame_err_o    sticky: stop bit sampled low
//   overrun_err_o  sticky: word dropped because the FIFO was full
// ---------------------------------------------------------------------------
module yrv_aux_uart_rx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int OVS        = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          resetn_i,
  input  logic                          rxd_i,
  input  logic                          rx_en_i,
  input  logic [DIV_W-1:0]              div_val_i,
  input  logic                          rd_req_i,
  input  logic                          err_clr_i,
`ifdef AUX_UART_PARITY_EN
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  output logic                          parity_err_o,
`endif
  output logic [DATA_W-1:0]             rd_data_o,
  output logic                          rx_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          frame_err_o,
  output logic                          overrun_err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OVS_W = $clog2(OVS);
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e             state_q, state_d;
  logic [2:0]         sync_q;
  logic [DIV_W-1:0]   divCnt_q, divCnt_d;
  logic [OVS_W-1:0]   ovsCnt_q, ovsCnt_d;
  logic [OVS_W-1:0]   ovsTarget;
  logic [BIT_W-1:0]   bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0]  shift_q;
  logic               rxs, startEdge, tick, sampleNow, lastBit, parityOn;
  logic               sampleStart, sampleData, sampleStop;

  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]   count_q;
  logic               full, pop, wrAccept;
  logic               frameErr_q, overrunErr_q;

  // sync_q[1] is the synchronised line; sync_q[2] is its previous value
  // and is only used to spot the falling edge of a start bit.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) sync_q <= 3'b111;
    else           sync_q <= {sync_q[1:0], rxd_i};
  end

  assign rxs       = sync_q[1];
  assign startEdge = sync_q[2] & ~sync_q[1];

`ifdef AUX_UART_PARITY_EN
  assign parityOn = parity_en_i;
`else
  assign parityOn = 1'b0;
`endif

  // Start bit is sampled half a bit in; every later bit a full bit later,
  // which lands each sample at mid-bit.
  assign ovsTarget = (state_q == START) ? OVS_W'(OVS/2 - 1) : OVS_W'(OVS - 1);
  assign tick      = (state_q != IDLE) && (divCnt_q == div_val_i);
  assign sampleNow = tick && (ovsCnt_q == ovsTarget);
  assign lastBit   = (bitCnt_q == BIT_W'(DATA_W - 1));

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!rx_en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (startEdge) state_d = START;
        START:   if (sampleNow) state_d = rxs ? IDLE : DATA;
        DATA:    if (sampleNow && lastBit) state_d = parityOn ? PARITY : STOP;
        PARITY:  if (sampleNow) state_d = STOP;
        STOP:    if (sampleNow) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Sample strobes are gated with rx_en_i so an aborted frame never writes.
  always_comb begin
    sampleStart = rx_en_i && sampleNow && (state_q == START);
    sampleData  = rx_en_i && sampleNow && (state_q == DATA);
    sampleStop  = rx_en_i && sampleNow && (state_q == STOP);
  end

  // Tick divider and per-bit tick counter both sit at zero in IDLE so the
  // first tick after a start edge is a fixed distance from the edge.
  always_comb begin
    divCnt_d = divCnt_q;
    ovsCnt_d = ovsCnt_q;
    bitCnt_d = bitCnt_q;
    if (state_q == IDLE) begin
      divCnt_d = '0;
      ovsCnt_d = '0;
    end else begin
      divCnt_d = tick ? '0 : divCnt_q + DIV_W'(1);
      if (tick) ovsCnt_d = sampleNow ? '0 : ovsCnt_q + OVS_W'(1);
    end
    if (state_q != DATA) bitCnt_d = '0;
    else if (sampleData) bitCnt_d = bitCnt_q + BIT_W'(1);
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      divCnt_q <= '0;
      ovsCnt_q <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
    end else begin
      divCnt_q <= divCnt_d;
      ovsCnt_q <= ovsCnt_d;
      bitCnt_q <= bitCnt_d;
      if (sampleData) shift_q <= {rxs, shift_q[DATA_W-1:1]};
    end
  end

  // A write into a full FIFO is still accepted when the head is popped in
  // the same clock, since a slot frees up at that edge.
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop      = rd_req_i && (count_q != '0);
  assign wrAccept = sampleStop && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (wrAccept) mem_q[wrPtr_q] <= shift_q;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (wrAccept) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop)      rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(wrAccept) - CNT_W'(pop);
    end
  end

  // Sticky flags: a clear request beats a set arriving in the same clock.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      frameErr_q   <= 1'b0;
      overrunErr_q <= 1'b0;
    end else if (err_clr_i) begin
      frameErr_q   <= 1'b0;
      overrunErr_q <= 1'b0;
    end else begin
      if (sampleStop && !rxs)                frameErr_q   <= 1'b1;
      if (sampleStop && full && !pop)        overrunErr_q <= 1'b1;
    end
  end

`ifdef AUX_UART_PARITY_EN
  logic sampleParity, parityErr_q;

  assign sampleParity = rx_en_i && sampleNow && (state_q == PARITY);

  // Odd parity wants an odd number of ones across data plus parity bit.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i)                                              parityErr_q <= 1'b0;
    else if (err_clr_i)                                         parityErr_q <= 1'b0;
    else if (sampleParity && ((^shift_q ^ rxs) != parity_odd_i)) parityErr_q <= 1'b1;
  end

  assign parity_err_o = parityErr_q;
`endif

  assign rx_valid_o    = (count_q != '0);
  assign rd_data_o     = rx_valid_o ? mem_q[rdPtr_q] : '0;
  assign fifo_count_o  = count_q;
  assign frame_err_o   = frameErr_q;
  assign overrun_err_o = overrunErr_q;

endmodule
